// File: rtl/ks_sum_accumulator.sv
// Accumulates a programmed number of 5-bit {carry,sum} beats from an upstream
// 4-bit adder and presents the total with a sticky overflow flag.
module ks_sum_accumulator #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_ext;

  // One extra bit catches the carry out of the accumulator MSB.
  assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'({in_cout, in_sum});

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = (len == 4'd0) ? 5'd16 : {1'b0, len};
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // Abort freezes the partial total rather than folding in a last beat.
        if (in_valid && !abort) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_ks_sum_accumulator.sv
// Randomized bench for ks_sum_accumulator; expected totals come from an
// integer running-sum model of each transaction.
module tb_ks_sum_accumulator;
  localparam int ACC_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       len = '0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic [3:0]       in_sum = '0;
  logic             in_cout = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int beats [16];

  ks_sum_accumulator #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n beats (1..16) taken from beats[]; hold = cycles out_ready stays low in DONE;
  // mode 0 = normal handshake, 1 = abort in DONE, 2 = abort with handshake.
  task automatic run_txn(input int n, input int hold, input int mode);
    int  acc_m = 0;
    bit  ovf_m = 0;
    int  got = 0;
    int  cyc = 0;
    int  t;
    bit  v;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    start = 1'b1;
    len   = 4'(n % 16);
    @(negedge clk);
    start = 1'b0;
    while (got < n) begin
      chk("accum_in_ready", in_ready, 1);
      chk("accum_out_valid", out_valid, 0);
      v = (cyc > 60) || ($urandom_range(0, 2) != 0);
      in_valid = v;
      if (v) {in_cout, in_sum} = 5'(beats[got]);
      else   {in_cout, in_sum} = 5'($urandom);
      // Stray start with a different len must be ignored mid-accumulation.
      start = ($urandom_range(0, 7) == 0);
      len   = 4'($urandom);
      if (v) begin
        t = acc_m + beats[got];
        if (t >= (1 << ACC_W)) ovf_m = 1;
        acc_m = t % (1 << ACC_W);
        got++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      chk("done_out_valid", out_valid, 1);
      chk("done_in_ready", in_ready, 0);
      chk("done_acc", out_acc, acc_m);
      chk("done_ovf", out_ovf, ovf_m);
      if (h == hold) begin
        out_ready = (mode != 1);
        abort     = (mode != 0);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    abort     = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_ovf", out_ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic: 21 + 15 + 16 = 52
    beats[0] = 21; beats[1] = 15; beats[2] = 16;
    run_txn(3, 0, 0);
    chk("basic_acc_const", out_acc, 52);
    chk("basic_ovf_const", out_ovf, 0);

    // Overflow: 16 x 31 = 496 -> 0xF0 with ovf
    for (int i = 0; i < 16; i++) beats[i] = 31;
    run_txn(16, 0, 0);
    chk("ovf_acc_const", out_acc, 8'hF0);
    chk("ovf_flag_const", out_ovf, 1);

    // Backpressure in DONE for 5 cycles
    for (int i = 0; i < 16; i++) beats[i] = $urandom_range(0, 31);
    run_txn(7, 5, 0);

    // abort + start in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1; len = 4'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_in_ready", in_ready, 0);

    // abort in DONE, then abort coinciding with handshake
    for (int i = 0; i < 16; i++) beats[i] = $urandom_range(0, 31);
    run_txn(4, 2, 1);
    for (int i = 0; i < 16; i++) beats[i] = $urandom_range(0, 31);
    run_txn(5, 1, 2);

    // Random transactions
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 16; i++) beats[i] = $urandom_range(0, 31);
      run_txn($urandom_range(1, 16), $urandom_range(0, 5), 0);
    end

    // Reset between edges after 2 of 4 beats
    @(negedge clk);
    start = 1'b1; len = 4'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; {in_cout, in_sum} = 5'd3;
    @(negedge clk);
    {in_cout, in_sum} = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_acc", out_acc, 0);
    chk("midrst_ovf", out_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    beats[0] = 7;
    run_txn(1, 0, 0);
    chk("after_rst_acc", out_acc, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ks_sum_accumulator.md
KS_SUM_ACCUMULATOR -- requirements
Module: ks_sum_accumulator

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-high reset, rst.
REQ-002 Parameter ACC_W SHALL default to 8 and set the accumulator width (legal range 6..16).
REQ-003 Port clk: input, 1 bit; rising-edge clock.
REQ-004 Port rst: input, 1 bit; asynchronous active-high reset.
REQ-005 Port start: input, 1 bit; begin a new accumulation (honoured in IDLE only).
REQ-006 Port len: input, 4 bits; beats to accumulate, sampled with start; 0 means 16.
REQ-007 Port abort: input, 1 bit; synchronous return to IDLE.
REQ-008 Port in_valid: input, 1 bit; adder result beat is present.
REQ-009 Port in_sum: input, 4 bits; sum from the upstream 4-bit Kogge-Stone adder.
REQ-010 Port in_cout: input, 1 bit; carry_out from the upstream adder.
REQ-011 Port in_ready: output, 1 bit; block accepts a beat this cycle.
REQ-012 Port out_valid: output, 1 bit; final result is present.
REQ-013 Port out_ready: input, 1 bit; consumer accepts the result.
REQ-014 Port out_acc: output, ACC_W bits; accumulated total.
REQ-015 Port out_ovf: output, 1 bit; sticky accumulator-overflow flag.
REQ-016 Port busy: output, 1 bit; high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-018 IDLE: in_ready=0 and out_valid=0; on start=1 and abort=0, the block SHALL load acc=0, ovf=0 and cnt=(len==0 ? 16 : len), then enter ACCUM.
REQ-019 ACCUM: in_ready=1; a beat is accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-020 On each accepted beat, acc SHALL become (acc + {in_cout,in_sum}) mod 2^ACC_W, a 5-bit zero-extended addend, and cnt SHALL decrement by 1.
REQ-021 ovf SHALL be set when any accepted addition carries out of bit ACC_W-1, and SHALL stay set until the next start or reset.
REQ-022 When the beat that takes cnt from 1 to 0 is accepted in cycle k, the state SHALL be DONE in cycle k+1 with out_valid=1; in_ready SHALL be 0 in cycle k+1.
REQ-023 in_valid=0 in ACCUM SHALL leave acc, cnt and ovf unchanged; there is no timeout.
REQ-024 DONE: out_valid=1; out_acc and out_ovf SHALL hold stable while out_ready=0.
REQ-025 DONE with out_ready=1 SHALL complete the handshake and move to IDLE on the next edge.
REQ-026 A start arriving in ACCUM or DONE SHALL be ignored, with no effect on state, acc, cnt or len.
REQ-027 abort=1 SHALL force IDLE on the next edge from any state and drop out_valid; acc and ovf SHALL keep their values but not be presented (out_valid=0).
REQ-028 When abort and start are both 1 in IDLE, abort SHALL win and the state SHALL remain IDLE.
REQ-029 When abort=1 coincides with an accepted handshake in DONE, the result SHALL be counted as consumed and the state SHALL go to IDLE.
REQ-030 out_acc SHALL be driven from the acc register in every state; consumers SHALL qualify it only with out_valid.
REQ-031 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from in_valid or out_ready to any output.

Reset
REQ-032 Asserting rst SHALL immediately force state=IDLE, acc=0, cnt=0, ovf=0, in_ready=0, out_valid=0 and busy=0, independent of clk.
REQ-033 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial or pending result; after release the block SHALL accept a fresh start.
REQ-034 Deassertion of rst SHALL be synchronised to clk by the integrator; the block SHALL not start earlier than the first clk edge after release.

Verification
REQ-035 Basic: start, len=3; beats {1,0x5},{0,0xF},{1,0x0}, i.e. 21+15+16 -> out_acc=52 (0x34), out_ovf=0, out_valid exactly one cycle after the third beat.
REQ-036 Overflow: ACC_W=8, len=0 (16 beats) of {1,0xF}=31 each; total 496 -> out_acc=0xF0, out_ovf=1.
REQ-037 Backpressure: in_valid toggled randomly in ACCUM and out_ready held 0 for 5 cycles in DONE -> beats are counted only on handshakes, and out_acc/out_ovf stay stable until out_ready=1.
REQ-038 Control corners: start during ACCUM -> ignored; abort+start in IDLE -> stays IDLE; abort in DONE -> out_valid=0 next cycle.
REQ-039 Reset: rst pulsed between clock edges after 2 of 4 beats -> all outputs go to reset values at once; a following start with len=1 and beat {0,0x7} -> out_acc=7.
